// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the round-robin memory arbiter, its requesting cores and the RAM.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface mem_arbiter_rr_if #(
  parameter int NCORES = 8,
  parameter int AW     = 8,
  parameter int DW     = 8
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    wren;
  logic [NCORES*AW-1:0] Address;
  logic [NCORES*DW-1:0] Din;
`ifdef ARB_LOCK_EN
  logic [NCORES-1:0]    lock;
`endif
  logic [DW-1:0]        RAMq;
  logic [NCORES-1:0]    gnt;
  logic [NCORES-1:0]    done;
  logic [DW-1:0]        Dq;
  logic [AW-1:0]        RAMAddress;
  logic [DW-1:0]        RAMDin;
  logic                 RAMwren;

  // master: the cores plus the RAM read port; slave: the arbiter itself
  modport master (
    output req, wren, Address, Din,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output RAMq,
    input  gnt, done, Dq, RAMAddress, RAMDin, RAMwren
  );

  modport slave (
    input  req, wren, Address, Din,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  RAMq,
    output gnt, done, Dq, RAMAddress, RAMDin, RAMwren
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one synchronous RAM among NCORES cores, 4 cycles per access.
// Optional grant locking (up to MAX_HOLD back-to-back transactions) is enabled by ARB_LOCK_EN.
module mem_arbiter_rr #(
  parameter int NCORES   = 8,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_arbiter_rr_if.slave  bus
);

  localparam int IW = $clog2(NCORES);
  localparam logic [NCORES-1:0] ONE = NCORES'(1);

  if (NCORES < 2 || NCORES > 8 || MAX_HOLD < 1) begin : gBadParams
    $error("mem_arbiter_rr: NCORES must be 2..8 and MAX_HOLD at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT             state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     curCore;
  logic              isWrite;
  logic [NCORES-1:0] gntReg;
  logic [NCORES-1:0] doneReg;
  logic [DW-1:0]     dqReg;
  logic [AW-1:0]     ramAddrReg;
  logic [DW-1:0]     ramDinReg;
  logic              ramWrenReg;

  logic [IW-1:0]     winner;
  logic              anyReq;
  logic [IW-1:0]     selCore;
  logic [AW-1:0]     selAddr;
  logic [DW-1:0]     selDin;
  logic              selWren;
  logic [IW-1:0]     nextPtr;

`ifdef ARB_LOCK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]     holdCnt;
  logic              holdMore;
  assign holdMore = bus.lock[curCore] && bus.req[curCore] && (holdCnt < HW'(MAX_HOLD));
`endif

  // Scan downward so the requester closest above ptr (with wrap) is the last one written.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    winner = ptr;
    anyReq = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      cand = IW'(idx);
      if (bus.req[cand]) begin
        winner = cand;
        anyReq = 1'b1;
      end
    end
  end

  // A locked reissue resamples the core already holding the grant.
  assign selCore = (state == RESP) ? curCore : winner;

  always_comb begin
    selAddr = '0;
    selDin  = '0;
    selWren = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      if (selCore == IW'(k)) begin
        selAddr = bus.Address[k*AW +: AW];
        selDin  = bus.Din[k*DW +: DW];
        selWren = bus.wren[k];
      end
    end
  end

  assign nextPtr = (curCore == IW'(NCORES - 1)) ? '0 : curCore + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      curCore    <= '0;
      isWrite    <= 1'b0;
      gntReg     <= '0;
      doneReg    <= '0;
      dqReg      <= '0;
      ramAddrReg <= '0;
      ramDinReg  <= '0;
      ramWrenReg <= 1'b0;
`ifdef ARB_LOCK_EN
      holdCnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            gntReg     <= ONE << winner;
            curCore    <= winner;
            ramAddrReg <= selAddr;
            ramDinReg  <= selDin;
            ramWrenReg <= selWren;
            isWrite    <= selWren;
`ifdef ARB_LOCK_EN
            holdCnt    <= HW'(1);
`endif
            state      <= ISSUE;
          end else begin
            gntReg     <= '0;
            ramWrenReg <= 1'b0;
          end
        end
        ISSUE: begin
          ramWrenReg <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (!isWrite) dqReg <= bus.RAMq;
          doneReg <= ONE << curCore;
          state   <= RESP;
        end
        RESP: begin
          doneReg <= '0;
`ifdef ARB_LOCK_EN
          if (holdMore) begin
            ramAddrReg <= selAddr;
            ramDinReg  <= selDin;
            ramWrenReg <= selWren;
            isWrite    <= selWren;
            holdCnt    <= holdCnt + 1'b1;
            state      <= ISSUE;
          end else
`endif
          begin
            gntReg <= '0;
            ptr    <= nextPtr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gntReg;
  assign bus.done       = doneReg;
  assign bus.Dq         = dqReg;
  assign bus.RAMAddress = ramAddrReg;
  assign bus.RAMDin     = ramDinReg;
  assign bus.RAMwren    = ramWrenReg;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed self-checking bench for mem_arbiter_rr with a behavioural synchronous RAM.
// Lock scenarios are exercised only when ARB_LOCK_EN is defined.
module tb_mem_arbiter_rr;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  logic [7:0] ram [0:255];

  mem_arbiter_rr_if #(.NCORES(8), .AW(8), .DW(8)) bus ();

  mem_arbiter_rr #(.NCORES(8), .AW(8), .DW(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM reads back one cycle after sampling the address; reset preloads one known word.
  always @(posedge clk) begin
    if (!rst_n) ram[8'h3C] <= 8'hA5;
    else if (bus.RAMwren) ram[bus.RAMAddress] <= bus.RAMDin;
    bus.RAMq <= ram[bus.RAMAddress];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int core, input logic r, input logic w,
                               input logic [7:0] addr, input logic [7:0] din);
    bus.req[core]            = r;
    bus.wren[core]           = w;
    bus.Address[core*8 +: 8] = addr;
    bus.Din[core*8 +: 8]     = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input string tag, output logic [7:0] seen, output int at);
    bit timedOut;
    timedOut = 1'b1;
    seen     = '0;
    at       = cyc;
    for (int n = 0; n < 20 && timedOut; n++) begin
      tick();
      if (bus.done != 0) begin
        timedOut = 1'b0;
        seen     = bus.done;
        at       = cyc;
      end
    end
    checkOutput({tag, "Timeout"}, {31'b0, timedOut}, 32'd0);
  endtask

  // Lone request from an idle arbiter: grant, 1-cycle write pulse, done 3 cycles on.
  task automatic runTxn(input int core, input logic wr, input logic [7:0] addr,
                        input logic [7:0] din, input logic [7:0] expDq);
    applyStimulus(core, 1'b1, wr, addr, din);
    tick();
    checkOutput("gnt", bus.gnt, 32'(1) << core);
    checkOutput("ramWren", bus.RAMwren, wr);
    checkOutput("ramAddr", bus.RAMAddress, addr);
    if (wr) checkOutput("ramDin", bus.RAMDin, din);
    applyStimulus(core, 1'b1, ~wr, addr ^ 8'hFF, din ^ 8'hFF);
    tick();
    checkOutput("wrenPulse", bus.RAMwren, 0);
    checkOutput("doneEarly", bus.done, 0);
    checkOutput("ramAddrHeld", bus.RAMAddress, addr);
    tick();
    checkOutput("done", bus.done, 32'(1) << core);
    checkOutput("dq", bus.Dq, expDq);
    applyStimulus(core, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("doneClear", bus.done, 0);
    checkOutput("gntClear", bus.gnt, 0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] d;
    int         at;
    int         lastAt;
    int         strayCnt;
    logic [7:0] expSeq [5];

    checks      = 0;
    failures    = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.wren    = '0;
    bus.Address = '0;
    bus.Din     = '0;
`ifdef ARB_LOCK_EN
    bus.lock    = '0;
`endif

    repeat (3) tick();
    checkOutput("rstGnt", bus.gnt, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstDq", bus.Dq, 0);
    checkOutput("rstRamAddr", bus.RAMAddress, 0);
    checkOutput("rstRamDin", bus.RAMDin, 0);
    checkOutput("rstRamWren", bus.RAMwren, 0);
    rst_n = 1'b1;
    tick();

    runTxn(2, 1'b0, 8'h3C, 8'h00, 8'hA5);
    runTxn(5, 1'b1, 8'h40, 8'h77, 8'hA5);
    runTxn(1, 1'b0, 8'h40, 8'h00, 8'h77);
    runTxn(5, 1'b0, 8'h3C, 8'h00, 8'hA5);

    // ptr is now 6: core 7 must win over core 1, then core 1 after wrap.
    applyStimulus(1, 1'b1, 1'b0, 8'h3C, 8'h00);
    applyStimulus(7, 1'b1, 1'b0, 8'h40, 8'h00);
    waitDone("wrapFirst", d, lastAt);
    checkOutput("wrapFirstDone", d, 8'h80);
    checkOutput("wrapFirstDq", bus.Dq, 8'h77);
    applyStimulus(7, 1'b0, 1'b0, 8'h00, 8'h00);
    waitDone("wrapSecond", d, at);
    checkOutput("wrapSecondDone", d, 8'h02);
    checkOutput("wrapSecondDq", bus.Dq, 8'hA5);
    checkOutput("wrapGap", at - lastAt, 4);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Reset lands during ISSUE of a write from core 4 (ptr is 2).
    applyStimulus(4, 1'b1, 1'b1, 8'h55, 8'h99);
    tick();
    checkOutput("preRstGnt", bus.gnt, 8'h10);
    checkOutput("preRstWren", bus.RAMwren, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstWren", bus.RAMwren, 0);
    checkOutput("asyncRstGnt", bus.gnt, 0);
    applyStimulus(4, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    strayCnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.done != 0 || bus.gnt != 0) strayCnt++;
    end
    checkOutput("noDoneAfterRst", strayCnt, 0);

    // After reset core 0 has top priority; dropping req mid-flight must not abort.
    applyStimulus(4, 1'b1, 1'b0, 8'h3C, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    checkOutput("postRstGnt", bus.gnt, 8'h01);
    applyStimulus(4, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("droppedReqDone", bus.done, 8'h01);
    checkOutput("droppedReqDq", bus.Dq, 8'h77);
    tick();
    tick();
    checkOutput("idleAfterDrop", bus.gnt, 0);

    // All cores requesting continuously: strict rotation 0..7,0 every 4 cycles.
    pulseReset();
    for (int c = 0; c < 8; c++) applyStimulus(c, 1'b1, 1'b0, 8'h3C, 8'h00);
    lastAt = 0;
    for (int i = 0; i < 9; i++) begin
      waitDone("rotate", d, at);
      checkOutput($sformatf("rotateDone%0d", i), d, 32'(1) << (i % 8));
      checkOutput($sformatf("rotateGnt%0d", i), bus.gnt, 32'(1) << (i % 8));
      if (i > 0) checkOutput($sformatf("rotateGap%0d", i), at - lastAt, 4);
      lastAt = at;
    end
    bus.req = '0;
    repeat (4) tick();

`ifdef ARB_LOCK_EN
    // Core 3 locks: four back-to-back core-3 accesses, then rotation forces core 4.
    pulseReset();
    expSeq = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h10};
    bus.lock[3] = 1'b1;
    applyStimulus(3, 1'b1, 1'b0, 8'h3C, 8'h00);
    applyStimulus(4, 1'b1, 1'b0, 8'h40, 8'h00);
    for (int i = 0; i < 5; i++) begin
      waitDone("lock", d, at);
      checkOutput($sformatf("lockDone%0d", i), d, expSeq[i]);
    end
    bus.req  = '0;
    bus.lock = '0;
    repeat (4) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
